wb_regfile: RTL and testbench

Writeback stage and architectural register file of the pipelined CPU. Consumes the packed data/control bundle held in the MEM/WB pipeline register, selects the writeback value, and commits it to a 32×32-bit register file. Serves the ID stage's two read ports with same-cycle write bypass. Keeps a writeback counter for verification and debug.

---
 rtl/wb_regfile_pkg.sv | 44 ++++
 rtl/wb_regfile_regfile_2r1w.sv | 48 ++++
 rtl/wb_regfile.sv | 102 ++++++++++
 tb/tb_wb_regfile.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared CPU package: MEM/WB bundle layout, control bits and MemtoReg encodings.
// The MEM-stage packer uses the same constants, so both ends of the bundle agree.
package wb_regfile_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_AW    = 5;
    localparam int unsigned WB_W      = 133;
    localparam int unsigned CTR_W     = 3;
    localparam int unsigned MTR_W     = 2;

    // MEM/WB data bundle field positions
    localparam int unsigned WB_PC4_HI = 132;
    localparam int unsigned WB_PC4_LO = 101;
    localparam int unsigned WB_ALU_HI = 100;
    localparam int unsigned WB_ALU_LO = 69;
    localparam int unsigned WB_MEM_HI = 68;
    localparam int unsigned WB_MEM_LO = 37;
    localparam int unsigned WB_INS_HI = 36;
    localparam int unsigned WB_INS_LO = 5;
    localparam int unsigned WB_DST_HI = 4;
    localparam int unsigned WB_DST_LO = 0;

    // MEM/WB control bundle
    localparam int unsigned CTR_REGWRITE = 2;
    localparam int unsigned CTR_MTR_HI   = 1;
    localparam int unsigned CTR_MTR_LO   = 0;

    typedef enum logic [MTR_W-1:0] {
        MTR_ALU = 2'b00,
        MTR_MEM = 2'b01,
        MTR_PC4 = 2'b10,
        MTR_RSV = 2'b11
    } mtr_e;

    // Same layout as the constants above, for packers that prefer field names
    typedef struct packed {
        logic [XLEN-1:0]   pc4;
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   mem;
        logic [XLEN-1:0]   ins;
        logic [REG_AW-1:0] dst;
    } mem_wb_t;

endpackage

// File: rtl/wb_regfile_regfile_2r1w.sv
// Architectural register storage: one write port, two read ports plus a debug
// read port. Reads return stored contents only; register 0 always reads zero.
//   clk, reset        : clock, async active-low reset (clears all registers)
//   we_i/waddr_i/wdata_i : write port (writes to register 0 are ignored)
//   ra_a_i/rd_a_c, ra_b_i/rd_b_c, ra_d_i/rd_d_c : combinational read ports
module regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DW-1:0]     wdata_i,
    input  logic [REG_AW-1:0] ra_a_i,
    output logic [DW-1:0]     rd_a_c,
    input  logic [REG_AW-1:0] ra_b_i,
    output logic [DW-1:0]     rd_b_c,
    input  logic [REG_AW-1:0] ra_d_i,
    output logic [DW-1:0]     rd_d_c
);

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];

    // Next-state: single write, register 0 never written
    always_comb begin
        regs_d = regs_q;
        if (we_i && (waddr_i != '0)) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_a_c = (ra_a_i == '0) ? '0 : regs_q[ra_a_i];
    assign rd_b_c = (ra_b_i == '0) ? '0 : regs_q[ra_b_i];
    assign rd_d_c = (ra_d_i == '0) ? '0 : regs_q[ra_d_i];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage + register file. Selects the writeback value from the MEM/WB
// bundle, commits it, bypasses it to the ID read ports in the same cycle and
// counts effective writes.
//   wb_data/wb_ctr     : MEM/WB data and control bundles
//   rs/rt_addr, _data  : ID read ports with write-first bypass
//   wb_value/we/dest   : writeback info for the EX forwarding mux
//   wb_count           : effective writes since reset (wraps)
//   dbg_addr/dbg_data  : stored contents, no bypass
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WB_W-1:0]   wb_data,
    input  logic [CTR_W-1:0]  wb_ctr,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    output logic [DW-1:0]     rs_data,
    output logic [DW-1:0]     rt_data,
    output logic [DW-1:0]     wb_value,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_dest,
    output logic [31:0]       wb_count,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DW-1:0]     dbg_data
);

    logic [DW-1:0] pc4_val;
    logic [DW-1:0] alu_val;
    logic [DW-1:0] mem_val;
    logic          unused_ins;
    mtr_e          mtr_sel;

    logic [DW-1:0] rs_raw;
    logic [DW-1:0] rt_raw;
    logic [31:0]   count_q;
    logic [31:0]   count_d;

    assign pc4_val    = wb_data[WB_PC4_HI:WB_PC4_LO];
    assign alu_val    = wb_data[WB_ALU_HI:WB_ALU_LO];
    assign mem_val    = wb_data[WB_MEM_HI:WB_MEM_LO];
    assign wb_dest    = wb_data[WB_DST_HI:WB_DST_LO];
    // Instruction word rides along for debug only
    assign unused_ins = ^wb_data[WB_INS_HI:WB_INS_LO];

    assign mtr_sel = mtr_e'(wb_ctr[CTR_MTR_HI:CTR_MTR_LO]);

    // Writeback mux; reserved code falls back to the ALU result
    always_comb begin
        wb_value = alu_val;
        case (mtr_sel)
            MTR_MEM: wb_value = mem_val;
            MTR_PC4: wb_value = pc4_val;
            default: wb_value = alu_val;
        endcase
    end

    assign wb_we = wb_ctr[CTR_REGWRITE] && (wb_dest != '0);

    regfile_2r1w #(
        .NREG (NREG),
        .DW   (DW)
    ) u_rf (
        .clk     (clk),
        .reset   (reset),
        .we_i    (wb_we),
        .waddr_i (wb_dest),
        .wdata_i (wb_value),
        .ra_a_i  (rs_addr),
        .rd_a_c  (rs_raw),
        .ra_b_i  (rt_addr),
        .rd_b_c  (rt_raw),
        .ra_d_i  (dbg_addr),
        .rd_d_c  (dbg_data)
    );

    // Write-first bypass; wb_we already excludes register 0
    assign rs_data = (wb_we && (rs_addr == wb_dest)) ? wb_value : rs_raw;
    assign rt_data = (wb_we && (rt_addr == wb_dest)) ? wb_value : rt_raw;

    // Effective-write counter
    always_comb begin
        count_d = count_q;
        if (wb_we) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign wb_count = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic         clk;
    logic         reset;
    logic [132:0] wb_data;
    logic [2:0]   wb_ctr;
    logic [4:0]   rs_addr;
    logic [4:0]   rt_addr;
    logic [31:0]  rs_data;
    logic [31:0]  rt_data;
    logic [31:0]  wb_value;
    logic         wb_we;
    logic [4:0]   wb_dest;
    logic [31:0]  wb_count;
    logic [4:0]   dbg_addr;
    logic [31:0]  dbg_data;

    int n_pass;
    int n_total;

    wb_regfile dut (
        .clk      (clk),
        .reset    (reset),
        .wb_data  (wb_data),
        .wb_ctr   (wb_ctr),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .wb_value (wb_value),
        .wb_we    (wb_we),
        .wb_dest  (wb_dest),
        .wb_count (wb_count),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the MEM/WB bundle; instruction word gets a recognisable filler
    task automatic drive(input logic [2:0] ctr, input logic [31:0] pc4,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [4:0] dst);
        wb_ctr  = ctr;
        wb_data = {pc4, alu, mem, 32'hC0FFEE00, dst};
    endtask

    task automatic bubble();
        drive(3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bubble();
        rs_addr = 5'd3; rt_addr = 5'd3; dbg_addr = 5'd3;
        #12;
        n_total++; if (wb_count !== 32'd0) $display("FAIL reset_count got=%h exp=%h", wb_count, 32'd0); else n_pass++;
        n_total++; if (wb_we !== 1'b0) $display("FAIL reset_we got=%b exp=0", wb_we); else n_pass++;
        n_total++; if (wb_value !== 32'd0) $display("FAIL reset_value got=%h exp=0", wb_value); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        // Preload reg 3 from the ALU path
        drive(3'b100, 32'h0, 32'hA5A5A5A5, 32'h0, 5'd3);
        step();
        bubble();
        #1;
        n_total++; if (dbg_data !== 32'hA5A5A5A5) $display("FAIL preload_r3 got=%h exp=%h", dbg_data, 32'hA5A5A5A5); else n_pass++;
        n_total++; if (wb_count !== 32'd1) $display("FAIL preload_count got=%h exp=%h", wb_count, 32'd1); else n_pass++;
        // Mid-cycle reset while a write to reg 4 is being presented
        drive(3'b100, 32'h0, 32'h55AA55AA, 32'h0, 5'd4);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_total++; if (rs_data !== 32'd0) $display("FAIL async_reset_rs got=%h exp=0", rs_data); else n_pass++;
        n_total++; if (dbg_data !== 32'd0) $display("FAIL async_reset_dbg got=%h exp=0", dbg_data); else n_pass++;
        n_total++; if (wb_count !== 32'd0) $display("FAIL async_reset_count got=%h exp=0", wb_count); else n_pass++;
        // Edge while reset held with a write pending: write lost
        step();
        dbg_addr = 5'd4;
        #1;
        n_total++; if (dbg_data !== 32'd0) $display("FAIL reset_write_lost got=%h exp=0", dbg_data); else n_pass++;
        n_total++; if (wb_count !== 32'd0) $display("FAIL reset_write_count got=%h exp=0", wb_count); else n_pass++;
        @(negedge clk);
        bubble();
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mux();
        logic [31:0] exp_v [4];
        exp_v[0] = 32'h11111111;
        exp_v[1] = 32'h22222222;
        exp_v[2] = 32'h00400008;
        exp_v[3] = 32'h11111111;
        dbg_addr = 5'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive({1'b1, 2'(i)}, 32'h00400008, 32'h11111111, 32'h22222222, 5'd5);
            #1;
            n_total++; if (wb_value !== exp_v[i]) $display("FAIL mux_value sel=%0d got=%h exp=%h", i, wb_value, exp_v[i]); else n_pass++;
            n_total++; if (wb_we !== 1'b1 || wb_dest !== 5'd5) $display("FAIL mux_we_dest sel=%0d got=%b/%0d exp=1/5", i, wb_we, wb_dest); else n_pass++;
            step();
            n_total++; if (dbg_data !== exp_v[i]) $display("FAIL mux_stored sel=%0d got=%h exp=%h", i, dbg_data, exp_v[i]); else n_pass++;
        end
        @(negedge clk);
        bubble();
        #1;
        n_total++; if (wb_count !== 32'd4) $display("FAIL mux_count got=%h exp=%h", wb_count, 32'd4); else n_pass++;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        drive(3'b100, 32'h0, 32'h12345678, 32'h0, 5'd7);
        step();
        @(negedge clk);
        drive(3'b101, 32'h0, 32'h0, 32'hDEADBEEF, 5'd7);
        rs_addr = 5'd7; rt_addr = 5'd7; dbg_addr = 5'd7;
        #1;
        n_total++; if (rs_data !== 32'hDEADBEEF) $display("FAIL bypass_rs got=%h exp=%h", rs_data, 32'hDEADBEEF); else n_pass++;
        n_total++; if (rt_data !== 32'hDEADBEEF) $display("FAIL bypass_rt got=%h exp=%h", rt_data, 32'hDEADBEEF); else n_pass++;
        n_total++; if (dbg_data !== 32'h12345678) $display("FAIL bypass_dbg_old got=%h exp=%h", dbg_data, 32'h12345678); else n_pass++;
        rt_addr = 5'd5;
        #1;
        n_total++; if (rt_data !== 32'h11111111) $display("FAIL bypass_rt_indep got=%h exp=%h", rt_data, 32'h11111111); else n_pass++;
        step();
        n_total++; if (dbg_data !== 32'hDEADBEEF) $display("FAIL bypass_dbg_new got=%h exp=%h", dbg_data, 32'hDEADBEEF); else n_pass++;
        @(negedge clk);
        bubble();
        #1;
        n_total++; if (rs_data !== 32'hDEADBEEF) $display("FAIL bypass_stored_rs got=%h exp=%h", rs_data, 32'hDEADBEEF); else n_pass++;
        n_total++; if (wb_count !== 32'd6) $display("FAIL bypass_count got=%h exp=%h", wb_count, 32'd6); else n_pass++;
    endtask

    task automatic test_reg0();
        @(negedge clk);
        drive(3'b100, 32'h0, 32'hFFFFFFFF, 32'h0, 5'd0);
        rs_addr = 5'd0; dbg_addr = 5'd0;
        #1;
        n_total++; if (wb_we !== 1'b0) $display("FAIL reg0_we got=%b exp=0", wb_we); else n_pass++;
        n_total++; if (rs_data !== 32'd0) $display("FAIL reg0_rs got=%h exp=0", rs_data); else n_pass++;
        step();
        n_total++; if (wb_count !== 32'd6) $display("FAIL reg0_count got=%h exp=%h", wb_count, 32'd6); else n_pass++;
        n_total++; if (dbg_data !== 32'd0) $display("FAIL reg0_dbg got=%h exp=0", dbg_data); else n_pass++;
        @(negedge clk);
        bubble();
    endtask

    task automatic test_bubbles();
        logic [31:0] v;
        // Fresh reset so the count starts from zero
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            v = 32'h10000000 + 32'(i) * 32'h111;
            drive(3'b101, 32'h0, 32'h0, v, 5'(i));
            step();
            if (i % 2 == 1) begin
                // Bubble aimed at the register just written, with junk data
                @(negedge clk);
                drive(3'b001, 32'hBAD0BAD0, 32'hBAD0BAD0, 32'hBAD0BAD0, 5'(i));
                step();
            end
        end
        @(negedge clk);
        bubble();
        #1;
        n_total++; if (wb_count !== 32'd10) $display("FAIL bubble_count got=%h exp=%h", wb_count, 32'd10); else n_pass++;
        for (int i = 1; i <= 10; i++) begin
            dbg_addr = 5'(i);
            v = 32'h10000000 + 32'(i) * 32'h111;
            #1;
            n_total++; if (dbg_data !== v) $display("FAIL bubble_reg r=%0d got=%h exp=%h", i, dbg_data, v); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        bubble();
        force dut.count_q = 32'hFFFFFFFF;
        #1;
        release dut.count_q;
        #1;
        n_total++; if (wb_count !== 32'hFFFFFFFF) $display("FAIL wrap_preset got=%h exp=%h", wb_count, 32'hFFFFFFFF); else n_pass++;
        drive(3'b110, 32'h00400010, 32'h0, 32'h0, 5'd9);
        #1;
        n_total++; if (wb_value !== 32'h00400010) $display("FAIL wrap_pc4 got=%h exp=%h", wb_value, 32'h00400010); else n_pass++;
        step();
        n_total++; if (wb_count !== 32'd0) $display("FAIL wrap_count got=%h exp=0", wb_count); else n_pass++;
        @(negedge clk);
        bubble();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b0;
        rs_addr = '0;
        rt_addr = '0;
        dbg_addr = '0;
        bubble();
        test_reset();
        test_mux();
        test_bypass();
        test_reg0();
        test_bubbles();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
